// File: rtl/timer_seq_pkg.sv
// Shared definitions for the interval-timer sequencer: timer register map,
// control word encodings, sequencer states and the bus-cycle record.
package timer_seq_pkg;

    localparam logic [2:0] ADDR_STATUS   = 3'd0;
    localparam logic [2:0] ADDR_CONTROL  = 3'd1;
    localparam logic [2:0] ADDR_PERIOD_L = 3'd2;
    localparam logic [2:0] ADDR_PERIOD_H = 3'd3;

    localparam logic [15:0] CTRL_BIT_ITO   = 16'h0001;
    localparam logic [15:0] CTRL_BIT_CONT  = 16'h0002;
    localparam logic [15:0] CTRL_BIT_START = 16'h0004;
    localparam logic [15:0] CTRL_BIT_STOP  = 16'h0008;

    localparam logic [15:0] CTRL_START_ONESHOT = CTRL_BIT_START | CTRL_BIT_ITO;
    localparam logic [15:0] CTRL_STOP          = CTRL_BIT_STOP;

    typedef enum logic [3:0] {
        ST_INIT_STOP,
        ST_INIT_CLR,
        ST_IDLE,
        ST_LOAD_L,
        ST_LOAD_H,
        ST_START,
        ST_WAIT,
        ST_STOP,
        ST_CLEAR
    } seq_state_t;

    typedef struct packed {
        logic        cs;
        logic        write_n;
        logic [2:0]  addr;
        logic [15:0] data;
    } bus_t;

    localparam bus_t BUS_IDLE = '{cs: 1'b0, write_n: 1'b1, addr: 3'd0, data: 16'h0000};

    function automatic bus_t bus_write(input logic [2:0] addr, input logic [15:0] data);
        bus_t b;
        b.cs      = 1'b1;
        b.write_n = 1'b0;
        b.addr    = addr;
        b.data    = data;
        return b;
    endfunction

    // The timer counts period..0 inclusive, so a delay of N clocks needs period N-1;
    // anything below 2 ticks is clamped so the period never reaches 0.
    function automatic logic [31:0] calc_period(input logic [31:0] ticks);
        return (ticks < 32'd2) ? 32'd1 : ticks - 32'd1;
    endfunction

endpackage

// File: rtl/timer_seq_ctrl_rr_arbiter.sv
// Round-robin arbiter: combinational pick starting at the pointer, pointer
// advances past the winner whenever a grant is taken.
module rr_arbiter #(
    parameter int unsigned NREQ = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [NREQ-1:0] req,
    input  logic            take,
    output logic            any,
    output logic [2:0]      gnt_idx,
    output logic [NREQ-1:0] gnt_oh
);

    logic [2:0] ptr;
    logic       hi_found;
    logic       lo_found;
    logic [2:0] hi_idx;
    logic [2:0] lo_idx;

    // Lowest requester at or above the pointer wins; otherwise wrap to the lowest below it.
    always_comb begin
        hi_found = 1'b0;
        lo_found = 1'b0;
        hi_idx   = '0;
        lo_idx   = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (req[i]) begin
                if (3'(i) >= ptr) begin
                    if (!hi_found) begin
                        hi_found = 1'b1;
                        hi_idx   = 3'(i);
                    end
                end else if (!lo_found) begin
                    lo_found = 1'b1;
                    lo_idx   = 3'(i);
                end
            end
        end
        any     = hi_found | lo_found;
        gnt_idx = hi_found ? hi_idx : lo_idx;
        gnt_oh  = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            gnt_oh[i] = any && (3'(i) == gnt_idx);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr <= '0;
        end else if (take && any) begin
            ptr <= (gnt_idx == 3'(NREQ - 1)) ? 3'd0 : gnt_idx + 3'd1;
        end
    end

endmodule

// File: rtl/timer_seq_ctrl.sv
// Sequencer that time-shares one interval timer among NREQ one-shot delay
// requesters: program period/control, wait for irq or cancel, clear status.
module timer_seq_ctrl
    import timer_seq_pkg::*;
#(
    parameter int unsigned NREQ = 4,
    parameter int unsigned TW   = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NREQ-1:0]    req_valid,
    input  logic [NREQ*TW-1:0] req_ticks,
    output logic [NREQ-1:0]    req_ready,
    input  logic [NREQ-1:0]    cancel,
    output logic [NREQ-1:0]    done,
    output logic [NREQ-1:0]    aborted,
    output logic               busy,
    output logic [2:0]         grant_id,
    output logic [2:0]         m_address,
    output logic               m_chipselect,
    output logic               m_write_n,
    output logic [15:0]        m_writedata,
    input  logic               m_irq
);

    seq_state_t      state;
    seq_state_t      state_n;
    bus_t            bus_q;
    bus_t            bus_n;
    logic [NREQ-1:0] gmask;
    logic [NREQ-1:0] gmask_n;
    logic [TW-1:0]   period;
    logic [TW-1:0]   period_n;
    logic            abort_q;
    logic            abort_n;
    logic [NREQ-1:0] rdy_n;
    logic [NREQ-1:0] done_n;
    logic [NREQ-1:0] abt_n;
    logic            busy_n;
    logic [2:0]      gid_n;
    logic            take;
    logic            arb_any;
    logic [2:0]      arb_idx;
    logic [NREQ-1:0] arb_oh;
    logic [TW-1:0]   sel_ticks;

    rr_arbiter #(
        .NREQ(NREQ)
    ) u_arb (
        .clk     (clk),
        .reset   (reset),
        .req     (req_valid),
        .take    (take),
        .any     (arb_any),
        .gnt_idx (arb_idx),
        .gnt_oh  (arb_oh)
    );

    always_comb begin
        sel_ticks = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (arb_oh[i]) begin
                sel_ticks = req_ticks[i*TW +: TW];
            end
        end
    end

    always_comb begin
        state_n  = state;
        bus_n    = BUS_IDLE;
        rdy_n    = '0;
        done_n   = '0;
        abt_n    = '0;
        busy_n   = (state != ST_IDLE);
        gid_n    = grant_id;
        gmask_n  = gmask;
        period_n = period;
        abort_n  = abort_q;
        take     = 1'b0;
        unique case (state)
            ST_INIT_STOP: begin
                bus_n   = bus_write(ADDR_CONTROL, CTRL_STOP);
                state_n = ST_INIT_CLR;
            end
            ST_INIT_CLR: begin
                bus_n   = bus_write(ADDR_STATUS, 16'h0000);
                state_n = ST_IDLE;
            end
            ST_IDLE: begin
                if (arb_any) begin
                    take     = 1'b1;
                    rdy_n    = arb_oh;
                    gid_n    = arb_idx;
                    gmask_n  = arb_oh;
                    period_n = calc_period(sel_ticks);
                    state_n  = ST_LOAD_L;
                end
            end
            ST_LOAD_L: begin
                bus_n   = bus_write(ADDR_PERIOD_L, period[15:0]);
                state_n = ST_LOAD_H;
            end
            ST_LOAD_H: begin
                bus_n   = bus_write(ADDR_PERIOD_H, period[31:16]);
                state_n = ST_START;
            end
            ST_START: begin
                bus_n   = bus_write(ADDR_CONTROL, CTRL_START_ONESHOT);
                state_n = ST_WAIT;
            end
            ST_WAIT: begin
                // irq is checked first so a cancel racing the timeout still completes.
                if (m_irq) begin
                    abort_n = 1'b0;
                    state_n = ST_CLEAR;
                end else if (|(cancel & gmask)) begin
                    state_n = ST_STOP;
                end
            end
            ST_STOP: begin
                bus_n   = bus_write(ADDR_CONTROL, CTRL_STOP);
                abort_n = 1'b1;
                state_n = ST_CLEAR;
            end
            ST_CLEAR: begin
                bus_n = bus_write(ADDR_STATUS, 16'h0000);
                if (abort_q) begin
                    abt_n = gmask;
                end else begin
                    done_n = gmask;
                end
                state_n = ST_IDLE;
            end
            default: begin
                state_n = ST_INIT_STOP;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_INIT_STOP;
            bus_q     <= BUS_IDLE;
            req_ready <= '0;
            done      <= '0;
            aborted   <= '0;
            busy      <= 1'b0;
            grant_id  <= '0;
            gmask     <= '0;
            period    <= '0;
            abort_q   <= 1'b0;
        end else begin
            state     <= state_n;
            bus_q     <= bus_n;
            req_ready <= rdy_n;
            done      <= done_n;
            aborted   <= abt_n;
            busy      <= busy_n;
            grant_id  <= gid_n;
            gmask     <= gmask_n;
            period    <= period_n;
            abort_q   <= abort_n;
        end
    end

    assign m_chipselect = bus_q.cs;
    assign m_write_n    = bus_q.write_n;
    assign m_address    = bus_q.addr;
    assign m_writedata  = bus_q.data;

endmodule

// File: doc/timer_seq_ctrl.md
# timer_seq_ctrl

Sequencer and round-robin arbiter that shares the single 16-bit-register interval timer among NREQ one-shot delay requesters. It sits between requester logic and the timer's Avalon-MM slave port and is the timer's only master. Per grant it:
- programs period_l, period_h and control (START|ITO);
- waits for the timer irq;
- clears the timeout status;
- signals completion, or abort on cancel.

## Interface
- NREQ, 4: number of requesters, 2..8.
- TW, 32: request tick-count width, fixed to timer period width.
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  NREQ  per-requester delay request.
- req_ticks  in  NREQ*TW  per-requester delay in clk cycles; slice i belongs to requester i.
- req_ready  out  NREQ  one-cycle acceptance pulse, one-hot.
- cancel  in  NREQ  abort an in-flight request; honoured only for the granted index.
- done  out  NREQ  one-cycle completion pulse.
- aborted  out  NREQ  one-cycle cancel-acknowledge pulse.
- busy  out  1  sequencer not in IDLE.
- grant_id  out  3  index of the current or last grant.
- m_address  out  3  timer register address.
- m_chipselect  out  1  timer chip select.
- m_write_n  out  1  active-low write strobe.
- m_writedata  out  16  timer write data.
- m_irq  in  1  timer interrupt.

## Operation
- The timer slave has no waitrequest. Each write occupies exactly one cycle with m_chipselect=1 and m_write_n=0. No reads are issued.
- Register map:
  - 0 status: any write clears timeout.
  - 1 control: bit0 ITO, bit1 CONT, bit2 START, bit3 STOP.
  - 2 period_l.
  - 3 period_h.
- States: INIT_STOP, INIT_CLR, IDLE, LOAD_L, LOAD_H, START, WAIT, STOP, CLEAR.
- **INIT_STOP** writes control=0x0008. **INIT_CLR** writes status=0. The block then enters IDLE. This purges any timer state or irq left from before this block's reset.
- **IDLE**:
  - If any req_valid is set, the round-robin arbiter picks index g.
  - In the same cycle: req_ready[g]=1, ticks are latched, grant_id←g, next state LOAD_L.
  - Priority search starts at last grant + 1, modulo NREQ. The pointer resets to 0.
- **Tick arithmetic**: period = max(ticks,2) − 1, in 32 bits. Ticks 0 and 1 are clamped to 2.
- **LOAD_L** writes period[15:0] to address 2. **LOAD_H** writes period[31:16] to address 3.
- **START** writes control=0x0005 (START|ITO, one-shot). The timer's reload and start coincide; start takes priority.
- **WAIT** idles the bus:
  - If m_irq=1, go to CLEAR as a completion.
  - Else if cancel[grant_id]=1, go to STOP.
  - m_irq and cancel in the same cycle: completion wins and cancel is ignored.
- **STOP** writes control=0x0008, then goes to CLEAR as an abort.
- **CLEAR**:
  - Writes status (address 0, data 0).
  - Pulses done[grant_id] or aborted[grant_id].
  - Returns to IDLE.
- Cancel outside WAIT, or for a non-granted index, is ignored.
- A requester must hold req_valid and req_ticks stable until req_ready. Deasserting req_valid before grant withdraws the request.
- While busy, req_ready stays 0. New requests queue implicitly via held req_valid.

## Timing
- Reset values:
  - state=INIT_STOP.
  - m_chipselect=0, m_write_n=1, m_address=0, m_writedata=0.
  - req_ready=0, done=0, aborted=0, busy=0, grant_id=0, rr pointer=0.
- All outputs are registered. The bus is driven idle (cs=0, write_n=1, address=0, data=0) in IDLE and WAIT.
- After reset deasserts, the two init writes occur on cycles 1 and 2. The first req_ready can fire on cycle 3.
- Grant latency from IDLE is 0 cycles: req_ready coincides with the arbitration cycle.
- Grant to START write: 3 cycles (LOAD_L, LOAD_H, START on grant+1..+3).
- Completion: done pulses in the cycle after the first cycle m_irq is sampled high. busy drops the following cycle.
- Back-to-back grants: at least 6 cycles apart, since IDLE is re-entered after CLEAR.
- Reset asserted mid-operation: the block returns to the reset state and no done or aborted pulse is issued. The INIT sequence stops the timer and clears any pending irq.

## Structure
- Package timer_seq_pkg holds:
  - register address constants (ADDR_STATUS=0, ADDR_CONTROL=1, ADDR_PERIOD_L=2, ADDR_PERIOD_H=3);
  - control bit constants and CTRL_START_ONESHOT=16'h0005, CTRL_STOP=16'h0008;
  - the state enum.
- One sub-module, rr_arbiter:
  - NREQ-wide, combinational pick from req_valid plus a pointer;
  - registered pointer update on grant.
- The top module holds the FSM, tick latch and bus registers.

## Test plan
- Reset release with m_irq=1 held → writes (1,0x0008) then (0,0); no req_ready for 2 cycles; done stays 0.
- Requester 2 asks ticks=100; timer model raises irq 100 cycles after START → writes (2,99),(3,0),(1,5); done[2] pulses once; busy falls.
- All four req_valid high, ticks=10 each → grants in order 0,1,2,3, then 0 again; each req_ready is one-hot and ≥6 cycles apart.
- ticks=0x00012345 → period_l=0x2344, period_h=0x0001; ticks=1 → period written as 1.
- cancel[grant_id] during WAIT → write (1,0x0008) then (0,0); aborted pulses and done does not. cancel asserted together with m_irq → done only.
- reset asserted during WAIT → no done; after release the INIT writes repeat and the pending request is re-arbitrated from pointer 0.
